if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register, drives the synchronous instruction SRAM, and produces the `{ce, pc}` bus and a stable instruction word for the decode stage. It consumes the decode stage's branch bus `{br_e, br_addr}` as the redirect source. It also captures the SRAM output while the IF/ID boundary is stalled, so decode never needs its own instruction latch.

## Interface
- `RESET_PC`, 32'hBFC0_0000, address of the first instruction fetched after reset.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  `StallBus` (6)  stall vector. Bit 0 is the PC stage and bit 1 is the IF/ID boundary. `Stop`=1, `NoStop`=0.
- `br_bus`  in  `BR_WD` (33)  `{br_e[32], br_addr[31:0]}` from decode.
- `if_to_id_bus`  out  `IF_TO_ID_WD` (33)  `{ce[32], pc[31:0]}`.
- `if_inst`  out  32  instruction word belonging to the PC currently held in the decode register.
- `inst_sram_en`  out  1  SRAM read enable.
- `inst_sram_wen`  out  4  always 4'b0000.
- `inst_sram_addr`  out  32  equals `pc_reg`.
- `inst_sram_wdata`  out  32  always 0.
- `inst_sram_rdata`  in  32  SRAM data, valid one cycle after an enabled read.
- `if_excp`  out  1  fetch address error. Tied to 0 unless `IF_ADEL_CHECK_EN` is defined.

## Operation
- **State.** The block holds `pc_reg[31:0]`, `ce_reg`, `inst_hold[31:0]` and `hold_valid`.
- **FSM.** The four states are IDLE (`ce_reg`=0), RUN, HOLD and BUBBLE.
  - RUN, HOLD and BUBBLE are all `ce_reg`=1. HOLD and BUBBLE are the two ways `hold_valid`=1 gets set.
- **Reset.** Reset sets:
  - `pc_reg`=`RESET_PC`-4
  - `ce_reg`=0
  - `hold_valid`=0
  - `inst_hold`=0
- **Next PC.** `next_pc` = `br_e` ? `br_addr` : `pc_reg`+4, with 32-bit wrap (0xFFFF_FFFC+4 = 0).
- **PC update.**
  - IDLE→RUN: on the first posedge with `rst`=0, `ce_reg`<=1 and `pc_reg`<=`next_pc`.
  - While `stall[0]`=`Stop`: `pc_reg` and `ce_reg` hold.
  - Otherwise: `pc_reg`<=`next_pc`.
- **SRAM port.** `inst_sram_en`=`ce_reg`, and it stays asserted during stalls. The SRAM re-reads the held PC, so when a stall releases the data for `pc_reg` arrives on the following cycle.
- **Outputs.** `if_to_id_bus`={`ce_reg`, `pc_reg`}. `if_inst` = `hold_valid` ? `inst_hold` : `inst_sram_rdata`.
- **Hold capture.** Evaluated at each posedge, in priority order:
  1. `rst`: `hold_valid`<=0.
  2. `stall[1]`=`Stop`, `stall[2]`=`NoStop`, `hold_valid`=0 (BUBBLE): `inst_hold`<=0 and `hold_valid`<=1. Decode receives a zero bus, so `if_inst` must read as a NOP.
  3. `stall[1]`=`Stop`, `hold_valid`=0 (HOLD): `inst_hold`<=`inst_sram_rdata` and `hold_valid`<=1.
  4. `stall[1]`=`Stop`, `hold_valid`=1: no change. Holding persists across multi-cycle stalls.
  5. `stall[1]`=`NoStop`: `hold_valid`<=0 (→RUN).
- **Branch during stall.** Decode keeps `br_bus` stable while it is stalled. The redirect is taken on the first edge with `stall[0]`=`NoStop`.
- **Delay slot.** There is no squash logic. The instruction at branch PC+4 is always fetched and executed.

## Timing
- Fetch latency is 1 cycle. The instruction for PC p appears on `inst_sram_rdata` in the cycle after `pc_reg`=p. This is the same cycle decode holds p.
- Branch redirect: when `br_e`=1 in cycle t with no stall, `pc_reg`=`br_addr` in cycle t+1.
- `if_inst` is combinational from `hold_valid`/`inst_hold`/`inst_sram_rdata`. No extra cycle is added.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of stall or branch. `if_inst` then equals raw `inst_sram_rdata`.
- Reset values of the outputs:
  - `if_to_id_bus`={0, `RESET_PC`-4}
  - `inst_sram_en`=0
  - `if_excp`=0

## Configuration
- **`IF_ADEL_CHECK_EN` defined:** `adel` = `ce_reg` & (`pc_reg[1:0]`!=0).
  - When `adel`=1: `inst_sram_en`=0, `if_excp`=1, and `if_inst` is forced to 0 (NOP).
  - The PC still advances per `next_pc`.
  - `if_excp` follows `pc_reg` combinationally, including during stalls.
- **Not defined:** no alignment check. `if_excp` is constant 0, and a misaligned PC is presented to the SRAM unchanged.

## Test plan
- **Reset release:** `rst`=1 for 3 cycles, then 0 → in cycle 1 after release, `pc_reg`=0xBFC0_0000, `ce`=1, `inst_sram_en`=1; in the next cycles, `pc_reg` steps 0xBFC0_0004, 0xBFC0_0008.
- **Branch:** `br_bus`={1, 0xBFC0_0100} for one cycle at `pc_reg`=0xBFC0_0008 → next `pc_reg`=0xBFC0_0100, then 0xBFC0_0104.
- **Hold:** `stall`=6'b000111 for 3 cycles, with SRAM returning 0x8C82_0000 in the first stalled cycle and 0xDEAD_BEEF afterwards → `if_inst`=0x8C82_0000 throughout; `pc_reg` is frozen; after release, `if_inst` tracks `inst_sram_rdata` again.
- **Bubble:** `stall`=6'b000011 for 1 cycle → next cycle `if_inst`=0; the cycle after release, `if_inst` is the word for the held `pc_reg`.
- **Wrap:** force `pc_reg`=0xFFFF_FFFC with no branch → next `pc_reg`=0x0000_0000.
- **ADEL (macro on):** `br_bus`={1, 0xBFC0_0102} → `if_excp`=1, `inst_sram_en`=0, `if_inst`=0. With the macro off, `if_excp` stays 0 and `inst_sram_addr`=0xBFC0_0102.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction SRAM port and IF/ID instruction hold.
// Optional fetch alignment check enabled by defining IF_ADEL_CHECK_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic [31:0] if_inst,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_excp
);

    localparam logic STOP = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        BUBBLE
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst_hold_q;
    logic        ce;
    logic        hold_valid;
    logic        br_e;
    logic [31:0] br_addr;
    logic        adel;
    logic        unused_stall;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign unused_stall = ^stall[5:3];

    assign pc_d       = br_e ? br_addr : pc_q + 32'd4;
    assign ce         = (state_q != IDLE);
    assign hold_valid = (state_q == HOLD) || (state_q == BUBBLE);

    // PC advance and hold capture share one FSM; hold/bubble only arise once fetching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC - 32'd4;
            inst_hold_q <= '0;
        end else begin
            if (stall[0] != STOP) begin
                pc_q <= pc_d;
            end
            case (state_q)
                IDLE: begin
                    if (stall[0] != STOP) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (stall[1] == STOP) begin
                        if (stall[2] != STOP) begin
                            state_q     <= BUBBLE;
                            inst_hold_q <= '0;
                        end else begin
                            state_q     <= HOLD;
                            inst_hold_q <= inst_sram_rdata;
                        end
                    end
                end
                HOLD, BUBBLE: begin
                    if (stall[1] != STOP) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IF_ADEL_CHECK_EN
    assign adel = ce && (pc_q[1:0] != 2'b00);
`else
    assign adel = 1'b0;
`endif

    assign if_to_id_bus    = {ce, pc_q};
    assign inst_sram_en    = ce && !adel;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = '0;
    assign if_excp         = adel;
    assign if_inst         = adel ? 32'd0 : (hold_valid ? inst_hold_q : inst_sram_rdata);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table followed by a randomised run
// against a small behavioural model, both feeding an expected-value scoreboard queue.
module tb_if_stage;

    localparam logic [31:0] RPC  = 32'hBFC0_0000;
    localparam logic [31:0] RPC4 = 32'hBFBF_FFFC;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic [31:0] if_inst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        if_excp;

    if_stage #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .if_inst         (if_inst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .if_excp         (if_excp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        br_e;
        logic [31:0] br_addr;
        logic [31:0] rdata;
        logic        ce;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic        en;
    } vec_t;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic        en;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba,
                       input logic [31:0] rd, input logic ce, input logic [31:0] pc,
                       input logic [31:0] inst, input logic excp, input logic en);
        vec_t v;
        v = '{r, s, be, ba, rd, ce, pc, inst, excp, en};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba,
                         input logic [31:0] rd);
        rst             = r;
        stall           = s;
        br_bus          = {be, ba};
        inst_sram_rdata = rd;
    endtask

    task automatic compare(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard step %0d: got empty queue want entry", idx);
        end else begin
            e = sb.pop_front();
            chk("ce",    idx, {31'd0, if_to_id_bus[32]}, {31'd0, e.ce});
            chk("pc",    idx, if_to_id_bus[31:0], e.pc);
            chk("addr",  idx, inst_sram_addr, e.pc);
            chk("en",    idx, {31'd0, inst_sram_en}, {31'd0, e.en});
            chk("inst",  idx, if_inst, e.inst);
            chk("excp",  idx, {31'd0, if_excp}, {31'd0, e.excp});
            chk("wen",   idx, {28'd0, inst_sram_wen}, 32'd0);
            chk("wdata", idx, inst_sram_wdata, 32'd0);
        end
    endtask

    // behavioural model for the randomised phase
    logic        m_valid, m_ce, m_hv;
    logic [31:0] m_pc, m_hold;

    initial begin
        // rst stall be  br_addr        rdata          ce  pc             inst           excp en
        add(1, 6'h00, 0, 32'h0,         32'h0,         0,  RPC4,          32'h0,         0,   0);
        add(1, 6'h00, 0, 32'h0,         32'h0,         0,  RPC4,          32'h0,         0,   0);
        add(0, 6'h00, 0, 32'h0,         32'h1111_0002, 0,  RPC4,          32'h1111_0002, 0,   0);
        add(0, 6'h00, 0, 32'h0,         32'h1111_0003, 1,  32'hBFC0_0000, 32'h1111_0003, 0,   1);
        add(0, 6'h00, 0, 32'h0,         32'h1111_0004, 1,  32'hBFC0_0004, 32'h1111_0004, 0,   1);
        add(0, 6'h00, 1, 32'hBFC0_0100, 32'h1111_0005, 1,  32'hBFC0_0008, 32'h1111_0005, 0,   1);
        add(0, 6'h00, 0, 32'h0,         32'h1111_0006, 1,  32'hBFC0_0100, 32'h1111_0006, 0,   1);
        add(0, 6'h07, 0, 32'h0,         32'h8C82_0000, 1,  32'hBFC0_0104, 32'h8C82_0000, 0,   1);
        add(0, 6'h07, 0, 32'h0,         32'hDEAD_BEEF, 1,  32'hBFC0_0104, 32'h8C82_0000, 0,   1);
        add(0, 6'h07, 0, 32'h0,         32'hDEAD_BEEF, 1,  32'hBFC0_0104, 32'h8C82_0000, 0,   1);
        add(0, 6'h00, 0, 32'h0,         32'hDEAD_BEEF, 1,  32'hBFC0_0104, 32'h8C82_0000, 0,   1);
        add(0, 6'h03, 0, 32'h0,         32'h1111_000B, 1,  32'hBFC0_0108, 32'h1111_000B, 0,   1);
        add(0, 6'h00, 0, 32'h0,         32'h1111_000C, 1,  32'hBFC0_0108, 32'h0,         0,   1);
        add(0, 6'h07, 1, 32'h0000_0200, 32'h1111_000D, 1,  32'hBFC0_010C, 32'h1111_000D, 0,   1);
        add(0, 6'h00, 1, 32'h0000_0200, 32'h1111_000E, 1,  32'hBFC0_010C, 32'h1111_000D, 0,   1);
        add(0, 6'h00, 1, 32'hFFFF_FFFC, 32'h1111_000F, 1,  32'h0000_0200, 32'h1111_000F, 0,   1);
        add(0, 6'h00, 0, 32'h0,         32'h1111_0010, 1,  32'hFFFF_FFFC, 32'h1111_0010, 0,   1);
        add(1, 6'h07, 1, 32'h0000_0200, 32'h1111_0011, 1,  32'h0000_0000, 32'h1111_0011, 0,   1);
        add(0, 6'h00, 0, 32'h0,         32'h1111_0012, 0,  RPC4,          32'h1111_0012, 0,   0);
        add(0, 6'h00, 1, 32'hBFC0_0102, 32'h1111_0013, 1,  32'hBFC0_0000, 32'h1111_0013, 0,   1);
`ifdef IF_ADEL_CHECK_EN
        add(0, 6'h00, 0, 32'h0,         32'h1111_0014, 1,  32'hBFC0_0102, 32'h0,         1,   0);
        add(0, 6'h00, 0, 32'h0,         32'h1111_0015, 1,  32'hBFC0_0106, 32'h0,         1,   0);
`else
        add(0, 6'h00, 0, 32'h0,         32'h1111_0014, 1,  32'hBFC0_0102, 32'h1111_0014, 0,   1);
        add(0, 6'h00, 0, 32'h0,         32'h1111_0015, 1,  32'hBFC0_0106, 32'h1111_0015, 0,   1);
`endif

        drive(1, 6'h00, 0, 32'h0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br_e, vecs[i].br_addr, vecs[i].rdata);
            e = '{vecs[i].ce, vecs[i].pc, vecs[i].inst, vecs[i].excp, vecs[i].en};
            sb.push_back(e);
            #1;
            compare(i);
            @(negedge clk);
        end

        // randomised phase; first cycle is reset so the model starts from a known state
        m_valid = 1'b0;
        m_ce = 1'b0; m_hv = 1'b0; m_pc = '0; m_hold = '0;
        for (int k = 0; k < 400; k++) begin
            logic        r, be;
            logic [5:0]  s;
            logic [31:0] ba, rd;
            int unsigned sel;
            exp_t        e;
            r   = (k == 0) || ($urandom_range(0, 49) == 0);
            sel = $urandom_range(0, 3);
            s   = (sel == 2) ? 6'h03 : (sel == 3) ? 6'h07 : 6'h00;
            be  = ($urandom_range(0, 3) == 0);
            ba  = $urandom & 32'hFFFF_FFFC;
            rd  = $urandom;
            drive(r, s, be, ba, rd);
            if (m_valid) begin
                e = '{m_ce, m_pc, m_hv ? m_hold : rd, 1'b0, m_ce};
                sb.push_back(e);
                #1;
                compare(1000 + k);
            end
            if (r) begin
                m_valid = 1'b1;
                m_ce = 1'b0; m_hv = 1'b0; m_pc = RPC - 32'd4; m_hold = '0;
            end else begin
                if (m_ce) begin
                    if (s[1]) begin
                        if (!m_hv) begin
                            m_hv   = 1'b1;
                            m_hold = s[2] ? rd : 32'd0;
                        end
                    end else begin
                        m_hv = 1'b0;
                    end
                end
                if (!s[0]) begin
                    m_pc = be ? ba : m_pc + 32'd4;
                    m_ce = 1'b1;
                end
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
